// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single combinational full-subtractor cell: d = a - b - bin, bout = borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             br_d;
  logic             d_s;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             sa_q;
  logic             sb_q;
  logic             ovf_q;
`endif

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_s),
    .bout (br_d)
  );

  // New difference bits enter at the MSB so the result lands aligned after WIDTH shifts.
  assign diff_d = {d_s, diff_q[WIDTH-1:1]};

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            sa_q       <= a[WIDTH-1];
            sb_q       <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            borrow_out_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= (sa_q != sb_q) && (d_s != sa_q);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [9];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands for one cycle; the accept edge happens inside.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_diff"},   {24'd0, diff},       {24'd0, v.exp_diff});
    check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, v.exp_borrow});
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"},    {31'd0, ovf},        {31'd0, v.exp_ovf});
`endif
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_out_valid", {31'd0, out_valid}, 32'd0);
    check("retire_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    int   cyc;
    vec_t v;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready",   {31'd0, in_ready},   32'd1);
    check("reset_out_valid",  {31'd0, out_valid},  32'd0);
    check("reset_diff",       {24'd0, diff},       32'd0);
    check("reset_borrow",     {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf",        {31'd0, ovf},        32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(cyc);
      check("latency", cyc, W);
      check_result("vec", vecs[i]);
      retire();
    end

    // Result must hold while the consumer stalls.
    v = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0};
    start_op(v.a, v.b);
    wait_done(cyc);
    check("stall_latency", cyc, W);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_result("stall", v);
    end
    retire();

    // Reset in the middle of SHIFT aborts the operation.
    start_op(8'h77, 8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_in_ready",  {31'd0, in_ready},  32'd1);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_diff",      {24'd0, diff},      32'd0);
    v = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    start_op(v.a, v.b);
    wait_done(cyc);
    check("after_reset_latency", cyc, W);
    check_result("after_reset", v);
    retire();

    // New operands and in_valid during SHIFT must be ignored.
    v = '{8'h20, 8'h30, 8'hF0, 1'b1, 1'b0};
    start_op(v.a, v.b);
    @(negedge clk);
    a        = 8'hFF;
    b        = 8'h00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    check("shift_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_done(cyc);
    check("ignore_latency", cyc, W - 2);
    check_result("ignore", v);
    retire();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
